dffram_wb_adapter: RTL

DFFRAM_WB_ADAPTER -- requirements
Module: dffram_wb_adapter

---
 rtl/dffram_wb_adapter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dffram_wb_adapter.sv
// Wishbone classic slave that fronts a single-port DFFRAM macro.
// All RAM-side and bus-side outputs are registered; an optional zero-fill sweep runs after reset.
module dffram_wb_adapter #(
    parameter int WSIZE         = 4,
    parameter int AWIDTH        = 6,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WSIZE-1:0]     wb_sel_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [WSIZE*8-1:0]   wb_dat_i,
    output logic [WSIZE*8-1:0]   wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 EN0,
    output logic [WSIZE-1:0]     WE0,
    output logic [AWIDTH-1:0]    A0,
    output logic [WSIZE*8-1:0]   Di0,
    input  logic [WSIZE*8-1:0]   Do0,
    output logic                 init_done
);

    localparam int DW = WSIZE * 8;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ACCESS,
        RWAIT,
        ACK
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic                en0_q, en0_d;
    logic [WSIZE-1:0]    we0_q, we0_d;
    logic [AWIDTH-1:0]   a0_q, a0_d;
    logic [DW-1:0]       di0_q, di0_d;
    logic                ack_q, ack_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic                init_done_q, init_done_d;
    logic                is_write_q, is_write_d;
    logic                req;

    // Byte-offset bits and everything above the word index alias onto the same RAM word.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:AWIDTH+2], wb_adr_i[1:0]};

    assign req = wb_cyc_i & wb_stb_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en0_d       = 1'b0;
        we0_d       = '0;
        a0_d        = a0_q;
        di0_d       = di0_q;
        ack_d       = 1'b0;
        dat_d       = dat_q;
        init_done_d = init_done_q;
        is_write_d  = is_write_q;

        case (state_q)
            INIT: begin
                en0_d = 1'b1;
                we0_d = '1;
                di0_d = '0;
                a0_d  = cnt_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                init_done_d = 1'b1;
                if (req) begin
                    en0_d      = 1'b1;
                    we0_d      = wb_we_i ? wb_sel_i : '0;
                    a0_d       = wb_adr_i[AWIDTH+1:2];
                    di0_d      = wb_dat_i;
                    is_write_d = wb_we_i;
                    state_d    = ACCESS;
                end
            end

            // A master that abandons the cycle still gets its RAM access, just no ack.
            ACCESS: begin
                if (is_write_q) begin
                    ack_d   = wb_cyc_i;
                    state_d = ACK;
                end else begin
                    state_d = RWAIT;
                end
            end

            RWAIT: begin
                dat_d   = Do0;
                ack_d   = wb_cyc_i;
                state_d = ACK;
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= INIT_ON_RESET ? INIT : IDLE;
            cnt_q       <= '0;
            en0_q       <= 1'b0;
            we0_q       <= '0;
            a0_q        <= '0;
            di0_q       <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            init_done_q <= ~INIT_ON_RESET;
            is_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en0_q       <= en0_d;
            we0_q       <= we0_d;
            a0_q        <= a0_d;
            di0_q       <= di0_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            init_done_q <= init_done_d;
            is_write_q  <= is_write_d;
        end
    end

    assign EN0       = en0_q;
    assign WE0       = we0_q;
    assign A0        = a0_q;
    assign Di0       = di0_q;
    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign init_done = init_done_q;

endmodule
